// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: owns the CPU-side bus shared by the 6502 core and the OAM DMA
// engine. A CPU write to DMA_REG_ADDR halts the CPU and copies the 256 bytes of
// page {written_byte,8'h00} to OAM_DATA_ADDR. Each byte is copied as a READ/WRITE
// pair. READ always starts on an even cycle. A one-cycle ALIGN is inserted when
// needed to keep that parity.
//
// Optional feature: define OAM_DMA_ABORT_EN to add the dma_abort input.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   cpu_addr/dout/rw_n    CPU pin-side address, write data, read(1)/write(0)
//   dma_abort             (OAM_DMA_ABORT_EN only) early termination request
//   cpu_rdata             read data to CPU; combinational copy of bus_rdata
//   cpu_halt              registered CPU stall, high for the whole transfer
//   bus_addr/wdata/rw_n   system bus side (combinational mux)
//   bus_rdata             system bus read data
//   dma_active            registered, high whenever the FSM is not IDLE
//   dma_done              registered one-cycle pulse after the final OAM write
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw_n,
`ifdef OAM_DMA_ABORT_EN
  input  logic        dma_abort,
`endif
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rw_n,
  input  logic [7:0]  bus_rdata,
  output logic        dma_active,
  output logic        dma_done
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] page_q, page_d;
  logic [DW-1:0] idx_q, idx_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cyc_odd_q, cyc_odd_d;
  logic          abort_pend_q, abort_pend_d;
  logic          cpu_halt_q, cpu_halt_d;
  logic          dma_active_q, dma_active_d;
  logic          dma_done_q, dma_done_d;
  logic          abort_req_c;
  logic          trigger_c;

  // Abort request, only honoured while a transfer is in flight.
`ifdef OAM_DMA_ABORT_EN
  assign abort_req_c = dma_abort;
`else
  assign abort_req_c = 1'b0;
`endif

  assign trigger_c = !cpu_rw_n && (cpu_addr == DMA_REG_ADDR);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      page_q       <= '0;
      idx_q        <= '0;
      rdata_q      <= '0;
      cyc_odd_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      cpu_halt_q   <= 1'b0;
      dma_active_q <= 1'b0;
      dma_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      rdata_q      <= rdata_d;
      cyc_odd_q    <= cyc_odd_d;
      abort_pend_q <= abort_pend_d;
      cpu_halt_q   <= cpu_halt_d;
      dma_active_q <= dma_active_d;
      dma_done_q   <= dma_done_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    rdata_d      = rdata_q;
    cyc_odd_d    = ~cyc_odd_q;
    abort_pend_d = abort_pend_q;
    dma_done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (trigger_c) begin
          page_d  = cpu_dout;
          idx_d   = '0;
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        if (abort_req_c) begin
          state_d    = ST_IDLE;
          dma_done_d = 1'b1;
        end else begin
          // Odd now means the next cycle is even, so READ can start directly.
          state_d = cyc_odd_q ? ST_READ : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (abort_req_c) begin
          state_d    = ST_IDLE;
          dma_done_d = 1'b1;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rdata_d = bus_rdata;
        state_d = ST_WRITE;
        // An abort in READ still lets the paired WRITE complete.
        if (abort_req_c) begin
          abort_pend_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if ((idx_q == 8'hFF) || abort_pend_q || abort_req_c) begin
          state_d      = ST_IDLE;
          dma_done_d   = 1'b1;
          abort_pend_d = 1'b0;
        end else begin
          idx_d   = idx_q + DW'(1);
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_halt_d   = (state_d != ST_IDLE);
    dma_active_d = (state_d != ST_IDLE);
  end

  // Bus mux: CPU passthrough in IDLE, forced dummy reads while halting, DMA otherwise.
  always_comb begin
    bus_addr  = cpu_addr;
    bus_wdata = cpu_dout;
    bus_rw_n  = cpu_rw_n;
    case (state_q)
      ST_HALT, ST_ALIGN: begin
        bus_rw_n = 1'b1;
      end
      ST_READ: begin
        bus_addr = AW'({page_q, idx_q});
        bus_rw_n = 1'b1;
      end
      ST_WRITE: begin
        bus_addr  = OAM_DATA_ADDR;
        bus_wdata = rdata_q;
        bus_rw_n  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign cpu_rdata  = bus_rdata;
  assign cpu_halt   = cpu_halt_q;
  assign dma_active = dma_active_q;
  assign dma_done   = dma_done_q;

endmodule
